seq_divider_8_by_4: RTL and testbench

SEQ_DIVIDER_8_BY_4 -- requirements
Module: seq_divider_8_by_4

---
 rtl/seq_divider_8_by_4_if.sv | 34 +++
 rtl/seq_divider_8_by_4.sv | 129 ++++++++++++
 tb/tb_seq_divider_8_by_4.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_8_by_4_if.sv
// Request/result bundle for the 8-by-4 sequential divider.
// Master issues divisions; slave is the divider itself.
interface seq_divider_8_by_4_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_divider_8_by_4.sv
// Restoring divider: 8-bit dividend by 4-bit divisor,
// one quotient bit per clock, MSB first, registered results.
module seq_divider_8_by_4 (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_divider_8_by_4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] prem_q, prem_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] dsr_q, dsr_d;
  logic       zero_q, zero_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  logic [4:0] shifted;
  logic [4:0] diff;
  logic       fits;

  // acc holds the unconsumed dividend bits on the left and
  // the quotient bits shifted in on the right.
  assign shifted = {prem_q[3:0], acc_q[7]};
  assign diff    = shifted - {1'b0, dsr_q};
  assign fits    = shifted >= {1'b0, dsr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    acc_d   = acc_q;
    dsr_d   = dsr_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d  = bus.dividend;
          dsr_d  = bus.divisor;
          prem_d = '0;
          cnt_d  = 4'd8;
          busy_d = 1'b1;
          zero_d = (bus.divisor == 4'd0);
          state_d = (bus.divisor == 4'd0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (fits) begin
          prem_d = diff;
          acc_d  = {acc_q[6:0], 1'b1};
        end else begin
          prem_d = shifted;
          acc_d  = {acc_q[6:0], 1'b0};
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (zero_q) begin
          quot_d = 8'hFF;
          rem_d  = 4'h0;
          dbz_d  = 1'b1;
        end else begin
          quot_d = acc_q;
          rem_d  = prem_q[3:0];
          dbz_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      acc_q   <= '0;
      dsr_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      acc_q   <= acc_d;
      dsr_q   <= dsr_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8_by_4.sv
// Bench for the 8-by-4 sequential divider: directed table,
// hand-written corner sequences, exhaustive and random sweeps.
module tb_seq_divider_8_by_4;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   viol;
  logic [7:0] last_q;
  logic [3:0] last_r;
  logic       last_z;

  seq_divider_8_by_4_if bus ();

  seq_divider_8_by_4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.busy && bus.done) viol++;
  end

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Issue one division; returns observed latency (0 = timeout).
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        input bit scramble, output int lat,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic z);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("accept_busy", bus.busy, 1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (scramble) begin
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
        bus.start    = 1'($urandom);
      end
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      chk("hold_q", bus.quotient, last_q);
      chk("hold_r", bus.remainder, last_r);
      chk("hold_z", bus.div_by_zero, last_z);
    end
    bus.start = 1'b0;
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    chk("done_not_busy", bus.busy, 0);
  endtask

  // Reference: plain integer division with the zero-divisor rule.
  task automatic check_model(input logic [7:0] a, input logic [3:0] b,
                             input int lat, input logic [7:0] q,
                             input logic [3:0] r, input logic z);
    int eq, er;
    if (b == 0) begin
      eq = 255; er = 0;
    end else begin
      eq = int'(a) / int'(b);
      er = int'(a) % int'(b);
    end
    chk("model_lat", lat, (b == 0) ? 1 : 9);
    chk("model_q", q, eq);
    chk("model_r", r, er);
    chk("model_z", z, (b == 0) ? 1 : 0);
    if (b != 0) begin
      chk("identity", int'(q) * int'(b) + int'(r), int'(a));
      chk("rem_lt_div", (r < b) ? 1 : 0, 1);
    end
    last_q = 8'(eq);
    last_r = 4'(er);
    last_z = (b == 0);
  endtask

  initial begin
    int lat;
    int dones;
    logic [7:0] q;
    logic [3:0] r;
    logic z;

    total = 0; passed = 0; viol = 0;
    last_q = '0; last_r = '0; last_z = 1'b0;
    vt[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9};
    vt[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9};
    vt[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 9};
    vt[3] = '{8'd123, 4'd0,  8'd255, 4'd0, 1'b1, 1};
    vt[4] = '{8'd10,  4'd3,  8'd3,   4'd1, 1'b0, 9};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_z", bus.div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      do_div(vt[i].a, vt[i].b, 1'b0, lat, q, r, z);
      chk("tbl_lat", lat, vt[i].lat);
      chk("tbl_q", q, vt[i].q);
      chk("tbl_r", r, vt[i].r);
      chk("tbl_z", z, vt[i].z);
      last_q = vt[i].q; last_r = vt[i].r; last_z = vt[i].z;
    end

    // Start pulse while busy must be ignored.
    @(posedge clk); #1;
    bus.dividend = 8'd100; bus.divisor = 4'd6; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.dividend = 8'd9; bus.divisor = 4'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0; lat = 0;
    for (int n = 4; n <= 24; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        if (lat == 0) begin
          lat = n;
          chk("ign_q", bus.quotient, 16);
          chk("ign_r", bus.remainder, 4);
          chk("ign_z", bus.div_by_zero, 0);
        end
      end
    end
    chk("ign_lat", lat, 9);
    chk("ign_dones", dones, 1);
    last_q = 8'd16; last_r = 4'd4; last_z = 1'b0;

    // Reset in the middle of a run; start during reset ignored.
    bus.dividend = 8'd77; bus.divisor = 4'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.dividend = 8'd9; bus.divisor = 4'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_q", bus.quotient, 0);
    chk("mid_rst_r", bus.remainder, 0);
    chk("mid_rst_z", bus.div_by_zero, 0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    chk("mid_rst_quiet", dones, 0);
    last_q = '0; last_r = '0; last_z = 1'b0;
    do_div(8'd77, 4'd5, 1'b0, lat, q, r, z);
    chk("post_rst_lat", lat, 9);
    chk("post_rst_q", q, 15);
    chk("post_rst_r", r, 2);
    last_q = 8'd15; last_r = 4'd2; last_z = 1'b0;

    // Exhaustive back-to-back sweep.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(8'(a), 4'(b), 1'b0, lat, q, r, z);
        check_model(8'(a), 4'(b), lat, q, r, z);
      end
    end

    // Random operands with input noise during the run.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      logic [3:0] rb;
      ra = 8'($urandom);
      rb = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      do_div(ra, rb, 1'b1, lat, q, r, z);
      check_model(ra, rb, lat, q, r, z);
    end

    chk("busy_done_excl", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
